// File: rtl/extend_pipe.sv
// extend_pipe: zero/sign/byte/half/upper extender feeding a DEPTH-entry FIFO.
// Each accepted word is extended at push time and stored with an error flag.
// Optional feature macro: EXT_CNT_EN adds a saturating 16-bit err_cnt output.
module extend_pipe #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int DEPTH     = 4,
  localparam int OFF_W    = ($clog2(IN_WIDTH/8) > 1) ? $clog2(IN_WIDTH/8) : 1,
  localparam int LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [2:0]           in_mode,
  input  logic [OFF_W-1:0]     in_off,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_err,
`ifdef EXT_CNT_EN
  output logic [15:0]          err_cnt,
`endif
  output logic [LVL_W-1:0]     level
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int NBYTES = IN_WIDTH / 8;
  localparam int NOFF   = 1 << OFF_W;

  // Offsets whose byte lies inside the input word.
  function automatic logic [NOFF-1:0] byte_mask();
    logic [NOFF-1:0] m;
    m = '0;
    for (int i = 0; i < NOFF; i++) m[i] = (i < NBYTES);
    return m;
  endfunction

  // Offsets that are half-aligned and whose half lies inside the input word.
  function automatic logic [NOFF-1:0] half_mask();
    logic [NOFF-1:0] m;
    m = '0;
    for (int i = 0; i < NOFF; i++) m[i] = ((i % 2) == 0) && ((i + 2) <= NBYTES);
    return m;
  endfunction

  localparam logic [NOFF-1:0] BYTE_OK = byte_mask();
  localparam logic [NOFF-1:0] HALF_OK = half_mask();

  logic [OUT_WIDTH:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]     r_level;
  logic [OUT_WIDTH-1:0] r_out_data;
  logic                 r_out_err;

  logic                 w_push;
  logic                 w_pop;
  logic [PTR_W-1:0]     w_next_rd;
  logic [LVL_W-1:0]     w_next_level;
  logic [IN_WIDTH-1:0]  w_shifted;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [OUT_WIDTH-1:0] w_res;
  logic                 w_err;

  assign in_ready  = (r_level != LVL_W'(DEPTH));
  assign out_valid = (r_level != LVL_W'(0));
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;
  assign level     = r_level;

  assign w_push       = in_valid & in_ready;
  assign w_pop        = out_valid & out_ready;
  assign w_next_rd    = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
  assign w_next_level = r_level + LVL_W'(w_push) - LVL_W'(w_pop);

  assign w_shifted = in_data >> {in_off, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = w_shifted[15:0];

  // Extension result and error flag for the word being presented.
  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    case (in_mode)
      3'b000: w_res = OUT_WIDTH'(in_data);
      3'b001: w_res = OUT_WIDTH'($signed(in_data));
      3'b010, 3'b011: begin
        if (BYTE_OK[in_off]) begin
          w_res = in_mode[0] ? OUT_WIDTH'($signed(w_byte)) : OUT_WIDTH'(w_byte);
        end else begin
          w_err = 1'b1;
        end
      end
      3'b100, 3'b101: begin
        if (HALF_OK[in_off]) begin
          w_res = in_mode[0] ? OUT_WIDTH'($signed(w_half)) : OUT_WIDTH'(w_half);
        end else begin
          w_err = 1'b1;
        end
      end
      3'b110:  w_res = OUT_WIDTH'(in_data) << (OUT_WIDTH - IN_WIDTH);
      default: w_err = 1'b1;
    endcase
  end

  // FIFO storage: write the extended entry at the write pointer on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= {w_err, w_res};
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr <= w_next_rd;
      r_level  <= w_next_level;
    end
  end

  // Registered head: next head entry, or hold the last popped value when draining empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
      r_out_err  <= 1'b0;
    end else if (w_next_level != LVL_W'(0)) begin
      if (w_push && (w_next_rd == r_wr_ptr)) begin
        r_out_data <= w_res;
        r_out_err  <= w_err;
      end else begin
        r_out_data <= r_mem[w_next_rd][OUT_WIDTH-1:0];
        r_out_err  <= r_mem[w_next_rd][OUT_WIDTH];
      end
    end
  end

`ifdef EXT_CNT_EN
  logic [15:0] r_err_cnt;
  assign err_cnt = r_err_cnt;

  // Saturating count of pushed entries flagged as errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 16'h0000;
    end else if (w_push && w_err && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_extend_pipe.sv
// Self-checking bench for extend_pipe (IN_WIDTH=16, OUT_WIDTH=32, DEPTH=4).
// A queue-based reference model predicts the FIFO contents; directed literals pin the model.
module tb_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [2:0]  in_mode;
  logic [0:0]  in_off;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic [2:0]  level;
`ifdef EXT_CNT_EN
  logic [15:0] err_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_off    (in_off),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
`ifdef EXT_CNT_EN
    .err_cnt   (err_cnt),
`endif
    .level     (level)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference extension computed with plain arithmetic: {err, data}.
  function automatic logic [32:0] ref_ext(input logic [15:0] d, input logic [2:0] m, input logic o);
    int unsigned b;
    int unsigned h;
    int unsigned r;
    r = 0;
    case (m)
      3'd0: return {1'b0, 32'(d)};
      3'd1: begin
        r = d;
        if (d >= 16'h8000) r = r + 32'hFFFF0000;
        return {1'b0, r};
      end
      3'd2, 3'd3: begin
        b = (int'(d) / (o ? 256 : 1)) % 256;
        r = b;
        if (m == 3'd3 && b >= 128) r = r + 32'hFFFFFF00;
        return {1'b0, r};
      end
      3'd4, 3'd5: begin
        if (o) return {1'b1, 32'h0};
        h = d;
        r = h;
        if (m == 3'd5 && h >= 32768) r = r + 32'hFFFF0000;
        return {1'b0, r};
      end
      3'd6: begin
        r = int'(d) * 65536;
        return {1'b0, r};
      end
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // Behavioural FIFO model.
  logic [32:0] mq[$];
  logic [32:0] m_last;
  logic [32:0] m_new;
  int          m_cnt;
  bit          m_acc;
  bit          m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_last = '0;
      m_cnt  = 0;
    end else begin
      m_acc = in_valid && (mq.size() < 4);
      m_pop = out_ready && (mq.size() > 0);
      m_new = ref_ext(in_data, in_mode, in_off[0]);
      if (m_pop) m_last = mq.pop_front();
      if (m_acc) begin
        mq.push_back(m_new);
        if (m_new[32] && m_cnt < 65535) m_cnt++;
      end
    end
  end

  // Compare DUT outputs with the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("level", 64'(level), 64'(mq.size()));
      check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      check("in_ready", 64'(in_ready), 64'(mq.size() != 4));
      if (mq.size() != 0) begin
        check("head_data", 64'(out_data), 64'(mq[0][31:0]));
        check("head_err", 64'(out_err), 64'(mq[0][32]));
      end else begin
        check("idle_data", 64'(out_data), 64'(m_last[31:0]));
        check("idle_err", 64'(out_err), 64'(m_last[32]));
      end
    end
  end

  task automatic push(input logic [15:0] d, input logic [2:0] m, input logic o);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_off   = o;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (k == 50) check("push_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push_check(input string name, input logic [15:0] d, input logic [2:0] m,
                            input logic o, input logic [31:0] exp_d, input logic exp_e);
    push(d, m, o);
    @(negedge clk);
    check({name, "_data"}, 64'(out_data), 64'(exp_d));
    check({name, "_err"}, 64'(out_err), 64'(exp_e));
  endtask

  logic [15:0] t4_vals [5];
  bit          acc;
  bit          rdy;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    in_mode   = 3'b000;
    in_off    = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Pin the model against hand-computed values.
    check("model_sext", 64'(ref_ext(16'h8001, 3'd1, 1'b0)), 64'h0_FFFF8001);
    check("model_bsext_off1", 64'(ref_ext(16'h80FF, 3'd3, 1'b1)), 64'h0_FFFFFF80);
    check("model_upper", 64'(ref_ext(16'hABCD, 3'd6, 1'b0)), 64'h0_ABCD0000);
    check("model_half_odd", 64'(ref_ext(16'hFFFF, 3'd4, 1'b1)), 64'h1_00000000);

    // Directed extension cases with literal results.
    push_check("t1_sext", 16'h8001, 3'b001, 1'b0, 32'hFFFF8001, 1'b0);
    push_check("t1_zext", 16'h8001, 3'b000, 1'b0, 32'h00008001, 1'b0);
    push_check("t2_bsext0", 16'h7F80, 3'b011, 1'b0, 32'hFFFFFF80, 1'b0);
    push_check("t2_bsext1", 16'h7F80, 3'b011, 1'b1, 32'h0000007F, 1'b0);
    push_check("t2_bzext0", 16'h7F80, 3'b010, 1'b0, 32'h00000080, 1'b0);
    push_check("t3_half_odd", 16'h7F80, 3'b101, 1'b1, 32'h00000000, 1'b1);
    push_check("t3_upper", 16'h1234, 3'b110, 1'b0, 32'h12340000, 1'b0);
    push_check("t3_reserved", 16'h1234, 3'b111, 1'b0, 32'h00000000, 1'b1);
    push_check("t3_hsext", 16'h9234, 3'b101, 1'b0, 32'hFFFF9234, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Back-pressure: fill to DEPTH, hold the fifth word, then drain.
    t4_vals[0] = 16'hA001; t4_vals[1] = 16'h0002; t4_vals[2] = 16'hB003;
    t4_vals[3] = 16'h0004; t4_vals[4] = 16'hC005;
    out_ready = 1'b0;
    in_mode   = 3'b001;
    in_off    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = t4_vals[i];
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("t4_level_full", 64'(level), 64'd4);
    check("t4_in_ready_low", 64'(in_ready), 64'd0);
    check("t4_head_A", 64'(out_data), 64'hFFFFA001);
    out_ready = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        acc = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    check("t4_E_accepted", 64'(acc), 64'd1);
    repeat (8) @(posedge clk);
    #1;

    // Asynchronous reset with three entries buffered.
    out_ready = 1'b0;
    push(16'h1111, 3'b000, 1'b0);
    push(16'h2222, 3'b111, 1'b0);
    push(16'h3333, 3'b001, 1'b0);
    @(negedge clk);
    check("t5_level3", 64'(level), 64'd3);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_level", 64'(level), 64'd0);
    check("t5_rst_data", 64'(out_data), 64'd0);
`ifdef EXT_CNT_EN
    check("t5_rst_cnt", 64'(err_cnt), 64'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("t5_post_valid", 64'(out_valid), 64'd0);

    // Randomized traffic with varying back-pressure.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      in_mode   = 3'($urandom_range(0, 7));
      in_off    = 1'($urandom_range(0, 1));
      out_ready = (c % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
`ifdef EXT_CNT_EN
    check("err_cnt", 64'(err_cnt), 64'(m_cnt));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
